// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encodings
// for the sequential ALU and its multiplier.
package alu_pkg;

  localparam logic [3:0] OP_PASS = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_LSL  = 4'b1000;
  localparam logic [3:0] OP_LSR  = 4'b1001;
  localparam logic [3:0] OP_ASR  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier, one bit of b per clock,
// low WIDTH bits kept; done pulses once when product is final.
module seq_mul #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             run;

  // The start edge already performs the first iteration on b[0].
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      run     <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        product <= b[0] ? a : '0;
        mcand   <= a << 1;
        mplier  <= b >> 1;
        cnt     <= CW'(1);
        run     <= 1'b1;
      end else if (run) begin
        if (mplier[0])
          product <= product + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle arith/logic/shift ops plus an
// iterative multiply, with registered result and flags.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  state_t           state;
  logic             accept;
  logic             is_mul;
  logic             mul_done;
  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] res_n;
  logic             c_n;
  logic             v_n;
  logic [WIDTH:0]   ext;
  logic [SHW-1:0]   sh;

  assign in_ready = (state == ST_IDLE) ||
                    (state == ST_HOLD && out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (op == OP_MUL);
  assign sh       = b[SHW-1:0];

  seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (accept && is_mul),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (prod)
  );

  // Shifts run on a WIDTH+1 vector so the spare bit catches
  // the last bit shifted out (and stays 0 for a zero amount).
  always_comb begin
    res_n = '0;
    c_n   = 1'b0;
    v_n   = 1'b0;
    ext   = '0;
    unique case (op)
      OP_PASS: res_n = b;
      OP_ADD: begin
        ext   = {1'b0, a} + {1'b0, b};
        res_n = ext[WIDTH-1:0];
        c_n   = ext[WIDTH];
        v_n   = (a[WIDTH-1] == b[WIDTH-1]) &&
                (res_n[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        ext   = {1'b0, a} + {1'b0, ~b} + 1'b1;
        res_n = ext[WIDTH-1:0];
        c_n   = ext[WIDTH];
        v_n   = (a[WIDTH-1] != b[WIDTH-1]) &&
                (res_n[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: res_n = a & b;
      OP_OR:  res_n = a | b;
      OP_XOR: res_n = a ^ b;
      OP_LSL: begin
        ext   = {1'b0, a} << sh;
        res_n = ext[WIDTH-1:0];
        c_n   = ext[WIDTH];
      end
      OP_LSR: begin
        ext   = {a, 1'b0} >> sh;
        res_n = ext[WIDTH:1];
        c_n   = ext[0];
      end
      OP_ASR: begin
        ext   = $signed({a, 1'b0}) >>> sh;
        res_n = ext[WIDTH:1];
        c_n   = ext[0];
      end
      default: res_n = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      negative  <= 1'b0;
      zero      <= 1'b1;
      overflow  <= 1'b0;
      carry_out <= 1'b0;
    end else if (accept && !is_mul) begin
      state     <= ST_HOLD;
      out_valid <= 1'b1;
      result    <= res_n;
      negative  <= res_n[WIDTH-1];
      zero      <= (res_n == '0);
      overflow  <= v_n;
      carry_out <= c_n;
    end else if (accept) begin
      state     <= ST_BUSY;
      out_valid <= 1'b0;
    end else if (state == ST_BUSY && mul_done) begin
      state     <= ST_HOLD;
      out_valid <= 1'b1;
      result    <= prod;
      negative  <= prod[WIDTH-1];
      zero      <= (prod == '0);
      overflow  <= 1'b0;
      carry_out <= 1'b0;
    end else if (state == ST_HOLD && out_ready) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed steps plus random ops
// compared against an arithmetic reference model.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int W  = 64;
  localparam int FW = W + 4;
  typedef logic [FW-1:0] fv_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic         negative;
  logic         zero;
  logic         overflow;
  logic         carry_out;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .negative  (negative),
    .zero      (zero),
    .overflow  (overflow),
    .carry_out (carry_out)
  );

  // {result, negative, zero, overflow, carry_out}
  function automatic fv_t model(input logic [3:0] o,
                                input logic [W-1:0] x,
                                input logic [W-1:0] y);
    logic [W-1:0] r;
    logic c;
    logic v;
    int s;
    r = '0;
    c = 1'b0;
    v = 1'b0;
    s = int'(y[$clog2(W)-1:0]);
    case (o)
      OP_PASS: r = y;
      OP_ADD: begin
        r = x + y;
        c = (r < x);
        v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      OP_SUB: begin
        r = x - y;
        c = (x >= y);
        v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_XOR: r = x ^ y;
      OP_LSL: begin
        r = x << s;
        c = (s == 0) ? 1'b0 : x[W-s];
      end
      OP_LSR: begin
        r = x >> s;
        c = (s == 0) ? 1'b0 : x[s-1];
      end
      OP_ASR: begin
        r = W'($signed(x) >>> s);
        c = (s == 0) ? 1'b0 : x[s-1];
      end
      OP_MUL: r = x * y;
      default: r = '0;
    endcase
    return {r, r[W-1], (r == '0), v, c};
  endfunction

  function automatic fv_t obs();
    return {result, negative, zero, overflow, carry_out};
  endfunction

  task automatic chk(input string tag, input fv_t o, input fv_t e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  task automatic run(input string tag, input logic [3:0] o,
                     input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    fv_t e;
    e = model(o, x, y);
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    chk({tag, "/rdy"}, fv_t'(in_ready), fv_t'(1));
    tick();
    in_valid = 1'b0;
    op = 4'($urandom);
    a = rnd();
    b = rnd();
    n = 1;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "/lat"}, fv_t'(n), fv_t'((o == OP_MUL) ? W + 1 : 1));
    chk(tag, obs(), e);
  endtask

  initial begin
    int n;
    bit seen;
    fv_t snap;
    fv_t e;
    logic [3:0] ro;

    tick();
    tick();
    chk("rst_hold", obs(), fv_t'({{W{1'b0}}, 4'b0100}));
    reset = 1'b0;

    // leave a pending result, then reset mid-cycle
    out_ready = 1'b0;
    op = OP_ADD;
    a = 64'd1;
    b = 64'd2;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", fv_t'(out_valid), fv_t'(1));
    #3 reset = 1'b1;
    #1;
    chk("async_rst_flags", obs(), fv_t'({{W{1'b0}}, 4'b0100}));
    chk("async_rst_ovalid", fv_t'(out_valid), fv_t'(0));
    chk("async_rst_irdy", fv_t'(in_ready), fv_t'(1));
    tick();
    reset = 1'b0;
    out_ready = 1'b1;

    run("add_ovf", OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    chk("add_ovf_lit", obs(),
        fv_t'({64'h8000_0000_0000_0000, 4'b1010}));
    run("sub_eq", OP_SUB, 64'd5, 64'd5);
    chk("sub_eq_lit", obs(), fv_t'({64'd0, 4'b0101}));
    run("sub_borrow", OP_SUB, 64'd0, 64'd1);
    run("asr4", OP_ASR, 64'h8000_0000_0000_0000, 64'd4);
    chk("asr4_lit", obs(),
        fv_t'({64'hF800_0000_0000_0000, 4'b1000}));
    run("lsl1", OP_LSL, 64'h8000_0000_0000_0001, 64'd1);
    chk("lsl1_lit", obs(), fv_t'({64'd2, 4'b0001}));
    run("lsr0", OP_LSR, 64'hFFFF_0000_0000_0001, 64'h40);
    run("lsr63", OP_LSR, 64'h8000_0000_0000_0000, 64'd63);
    run("illegal", 4'b0111, rnd(), rnd());
    run("pass", OP_PASS, rnd(), 64'h8000_0000_0000_0000);
    run("mul_max", OP_MUL, '1, '1);
    tick();

    // MUL with backpressure, inputs scrambled while busy
    out_ready = 1'b0;
    op = OP_MUL;
    a = 64'h1_0000_0003;
    b = 64'h1_0000_0002;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mul_busy_irdy", fv_t'(in_ready), fv_t'(0));
    n = 1;
    while (!out_valid && n < 200) begin
      op = 4'($urandom);
      a = rnd();
      b = rnd();
      tick();
      n++;
    end
    chk("mul_lat", fv_t'(n), fv_t'(65));
    chk("mul_res", obs(), fv_t'({64'h5_0000_0006, 4'b0000}));
    snap = obs();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_stable", obs(), snap);
      chk("hold_irdy", fv_t'(in_ready), fv_t'(0));
    end
    out_ready = 1'b1;
    tick();
    chk("hold_release", fv_t'(out_valid), fv_t'(0));

    // back-to-back XOR stream
    in_valid = 1'b1;
    op = OP_XOR;
    for (int i = 0; i < 8; i++) begin
      a = rnd();
      b = rnd();
      e = model(OP_XOR, a, b);
      chk("stream_irdy", fv_t'(in_ready), fv_t'(1));
      tick();
      chk("stream_ovalid", fv_t'(out_valid), fv_t'(1));
      chk("stream_res", obs(), e);
    end
    in_valid = 1'b0;
    tick();

    for (int i = 0; i < 30; i++) begin
      ro = 4'($urandom_range(0, 15));
      run("rand", ro, rnd(), rnd());
    end
    tick();

    // reset in the middle of a multiply
    op = OP_MUL;
    a = rnd();
    b = rnd();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (19) tick();
    #2 reset = 1'b1;
    #1;
    chk("abort_irdy", fv_t'(in_ready), fv_t'(1));
    tick();
    reset = 1'b0;
    chk("abort_first_irdy", fv_t'(in_ready), fv_t'(1));
    seen = 1'b0;
    repeat (80) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_ovalid", fv_t'(seen), fv_t'(0));
    run("post_abort_add", OP_ADD, 64'd2, 64'd3);
    chk("post_abort_lit", obs(), fv_t'({64'd5, 4'b0000}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
